csr_unit: RTL and testbench
===========================

Name: csr_unit

Overview:
- Machine-mode CSR file and trap sequencer, downstream of the instruction decoder.
- Consumes the decoder's CSR write-enable, mret and WFI indications, plus external and timer interrupt lines.
- Holds mstatus, mie, mip, mepc, mtvec, mcycle and minstret.
- Drives the `interrupt` input of the decoder, which releases the WFI stall.
- Drives a registered PC redirect (target plus valid pulse) to the fetch stage.

Parameters:
- MTVEC_RST, 32'h0001_0000, trap vector, reset value of mtvec (writable, bits[1:0] forced 0)
- XLEN, 32, data width; only 32 is supported

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  pipeline stall; EX-stage events are ignored while high
- csr_we  input  1  CSR write request from the EX-stage instruction
- csr_addr  input  12  CSR address
- csr_wdata  input  32  new CSR value, already computed (RW/RS/RC)
- csr_rdata  output  32  combinational read of csr_addr (pre-write value)
- mret  input  1  EX-stage instruction is MRET
- wfi  input  1  EX-stage instruction is WFI
- pc_ex  input  32  PC of the EX-stage instruction
- retire  input  1  one instruction retired this cycle
- ext_irq  input  1  external interrupt level (MEIP)
- tmr_irq  input  1  timer interrupt level (MTIP)
- interrupt  output  1  enabled interrupt pending; combinational
- redirect  output  1  one-cycle PC redirect pulse, registered
- redirect_pc  output  32  redirect target; valid when redirect=1

Behaviour:
- Reset (async, rst_n=0):
  - All CSRs = 0 except mtvec=MTVEC_RST and mstatus.MPP=2'b11.
  - FSM = RUN; redirect=0; redirect_pc=0.
- Registers:
  - mstatus: MIE bit3, MPIE bit7, MPP[12:11] hardwired 11; other bits read 0.
  - mie: MEIE bit11, MTIE bit7 writable; other bits 0.
  - mip: MEIP bit11 = ext_irq, MTIP bit7 = tmr_irq; read-only, writes ignored.
  - mepc: bits[1:0] forced 0.
- Counters:
  - mcycle (0xB00/0xB80) is a 64-bit counter incremented every cycle.
  - minstret (0xB02/0xB82) is a 64-bit counter incremented when retire=1.
  - Both wrap at 2^64 (carry from low half into high half).
  - A csr_we write to either half wins over that cycle's increment for that half only.
- Address map: 0x300 mstatus, 0x304 mie, 0x305 mtvec, 0x341 mepc, 0x344 mip. Any other address reads 0 and ignores writes.
- Enable/pending terms:
  - pend = (MEIP&MEIE) | (MTIP&MTIE)
  - interrupt = pend & MIE
- FSM states RUN, SLEEP, TRAP:
  - RUN, stall=1: no state change and no CSR write.
  - RUN, interrupt=1: highest priority.
    - mepc<=pc_ex, MPIE<=MIE, MIE<=0, discard csr_we.
    - Next state TRAP.
  - RUN, else mret=1: MIE<=MPIE, MPIE<=1; register redirect=1, redirect_pc=mepc; stay RUN.
  - RUN, else wfi=1: save pc_ex+4 in an internal wake_pc register; next state SLEEP.
  - RUN, else csr_we=1: write the CSR.
  - SLEEP: wait for pend=1; csr_we is ignored.
    - pend=1 and MIE=1: mepc<=wake_pc, MPIE<=1, MIE<=0; next state TRAP.
    - pend=1 and MIE=0: redirect=1, redirect_pc=wake_pc; next state RUN.
  - TRAP: redirect=1, redirect_pc={mtvec[31:2],2'b00} for exactly one cycle; next state RUN. Inputs are ignored in TRAP.
- Redirect: registered; it is asserted the cycle after the triggering decision, and redirect=0 in every other cycle.
- Simultaneous mret and interrupt: the interrupt wins and mret is not applied.
- Reset mid-SLEEP or mid-TRAP: returns to RUN with no redirect.

Test Plan:
- Reset, then read 0x305 / 0x300 → csr_rdata = 32'h0001_0000 / 32'h0000_1800; redirect=0.
- Write mie=0x800, then mstatus=0x8; raise ext_irq at pc_ex=0x120 → interrupt=1 that cycle. Next cycle: state TRAP, mepc=0x120, mstatus reads 0x1880. Following cycle: redirect=1, redirect_pc=0x0001_0000.
- With mepc=0x120 and MPIE=1, mret → next cycle redirect=1 with redirect_pc=0x120; mstatus reads 0x1888.
- wfi at pc_ex=0x200 with MIE=0, MTIE=1; raise tmr_irq 5 cycles later → redirect=1, redirect_pc=0x204; mepc unchanged.
- Load mcycle=32'hFFFF_FFFF and mcycleh=0 → two cycles later mcycleh=1 and the low half has wrapped. A write to 0xB00 coinciding with an increment stores the written value.
- csr_we to 0x305 concurrent with interrupt=1 → mtvec unchanged, mepc=pc_ex. stall=1 during an mret → no redirect and mstatus unchanged.

Source files
------------

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap sequencer. Holds mstatus, mie, mip, mepc,
// mtvec, mcycle and minstret. Raises the decoder's interrupt line and issues
// a registered PC redirect for mret, trap entry and WFI wake-up.
module csr_unit #(
   parameter logic [31:0] MTVEC_RST = 32'h0001_0000,
   parameter int          XLEN      = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            csr_we,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata,
   input  logic            mret,
   input  logic            wfi,
   input  logic [XLEN-1:0] pc_ex,
   input  logic            retire,
   input  logic            ext_irq,
   input  logic            tmr_irq,
   output logic            interrupt,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_SLEEP = 2'd1,
      ST_TRAP  = 2'd2
   } state_t;

   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MIE       = 12'h304;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MIP       = 12'h344;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;

   state_t            state_q, state_d;
   logic              mie_q, mie_d;        // mstatus.MIE
   logic              mpie_q, mpie_d;      // mstatus.MPIE
   logic              meie_q, meie_d;      // mie.MEIE
   logic              mtie_q, mtie_d;      // mie.MTIE
   logic [XLEN-1:0]   mepc_q, mepc_d;
   logic [XLEN-1:0]   mtvec_q, mtvec_d;
   logic [XLEN-1:0]   wake_pc_q, wake_pc_d;
   logic [63:0]       mcycle_q, mcycle_d;
   logic [63:0]       minstret_q, minstret_d;
   logic              redirect_q, redirect_d;
   logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;

   logic              pend_s;
   logic              csr_wr_s;

   assign pend_s    = (ext_irq & meie_q) | (tmr_irq & mtie_q);
   assign interrupt = pend_s & mie_q;

   assign redirect    = redirect_q;
   assign redirect_pc = redirect_pc_q;

   // Combinational CSR read returning the value held before any write this cycle.
   always_comb begin
      csr_rdata = 32'h0000_0000;
      case (csr_addr)
         A_MSTATUS:   csr_rdata = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
         A_MIE:       csr_rdata = {20'd0, meie_q, 3'd0, mtie_q, 7'd0};
         A_MTVEC:     csr_rdata = mtvec_q;
         A_MEPC:      csr_rdata = mepc_q;
         A_MIP:       csr_rdata = {20'd0, ext_irq, 3'd0, tmr_irq, 7'd0};
         A_MCYCLE:    csr_rdata = mcycle_q[31:0];
         A_MCYCLEH:   csr_rdata = mcycle_q[63:32];
         A_MINSTRET:  csr_rdata = minstret_q[31:0];
         A_MINSTRETH: csr_rdata = minstret_q[63:32];
         default:     csr_rdata = 32'h0000_0000;
      endcase
   end

   // Sequencer next state, trap/mret side effects, CSR writes and counter updates.
   always_comb begin
      state_d       = state_q;
      mie_d         = mie_q;
      mpie_d        = mpie_q;
      meie_d        = meie_q;
      mtie_d        = mtie_q;
      mepc_d        = mepc_q;
      mtvec_d       = mtvec_q;
      wake_pc_d     = wake_pc_q;
      redirect_d    = 1'b0;
      redirect_pc_d = 32'h0000_0000;
      csr_wr_s      = 1'b0;
      mcycle_d      = mcycle_q + 64'd1;
      minstret_d    = retire ? (minstret_q + 64'd1) : minstret_q;

      case (state_q)
         ST_RUN: begin
            if (stall) begin
               state_d = ST_RUN;
            end else if (interrupt) begin
               // Interrupt outranks mret/wfi/csr_we; the EX instruction is discarded.
               mepc_d  = {pc_ex[XLEN-1:2], 2'b00};
               mpie_d  = mie_q;
               mie_d   = 1'b0;
               state_d = ST_TRAP;
            end else if (mret) begin
               mie_d         = mpie_q;
               mpie_d        = 1'b1;
               redirect_d    = 1'b1;
               redirect_pc_d = mepc_q;
            end else if (wfi) begin
               wake_pc_d = pc_ex + 32'd4;
               state_d   = ST_SLEEP;
            end else if (csr_we) begin
               csr_wr_s = 1'b1;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_SLEEP: begin
            if (pend_s && mie_q) begin
               mepc_d  = {wake_pc_q[XLEN-1:2], 2'b00};
               mpie_d  = 1'b1;
               mie_d   = 1'b0;
               state_d = ST_TRAP;
            end else if (pend_s) begin
               // Pending but globally disabled: resume after the WFI.
               redirect_d    = 1'b1;
               redirect_pc_d = wake_pc_q;
               state_d       = ST_RUN;
            end else begin
               state_d = ST_SLEEP;
            end
         end
         ST_TRAP: begin
            redirect_d    = 1'b1;
            redirect_pc_d = {mtvec_q[XLEN-1:2], 2'b00};
            state_d       = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      if (csr_wr_s) begin
         case (csr_addr)
            A_MSTATUS: begin
               mie_d  = csr_wdata[3];
               mpie_d = csr_wdata[7];
            end
            A_MIE: begin
               meie_d = csr_wdata[11];
               mtie_d = csr_wdata[7];
            end
            A_MTVEC:     mtvec_d = {csr_wdata[XLEN-1:2], 2'b00};
            A_MEPC:      mepc_d  = {csr_wdata[XLEN-1:2], 2'b00};
            // Counter writes replace only the addressed half; the other half
            // still takes this cycle's increment (including carry).
            A_MCYCLE:    mcycle_d[31:0]    = csr_wdata;
            A_MCYCLEH:   mcycle_d[63:32]   = csr_wdata;
            A_MINSTRET:  minstret_d[31:0]  = csr_wdata;
            A_MINSTRETH: minstret_d[63:32] = csr_wdata;
            default:     csr_wr_s = 1'b1;  // unmapped or read-only: write dropped
         endcase
      end else begin
         csr_wr_s = 1'b0;
      end
   end

   // State, CSR and redirect registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         mie_q         <= 1'b0;
         mpie_q        <= 1'b0;
         meie_q        <= 1'b0;
         mtie_q        <= 1'b0;
         mepc_q        <= 32'h0000_0000;
         mtvec_q       <= {MTVEC_RST[31:2], 2'b00};
         wake_pc_q     <= 32'h0000_0000;
         mcycle_q      <= 64'd0;
         minstret_q    <= 64'd0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= 32'h0000_0000;
      end else begin
         state_q       <= state_d;
         mie_q         <= mie_d;
         mpie_q        <= mpie_d;
         meie_q        <= meie_d;
         mtie_q        <= mtie_d;
         mepc_q        <= mepc_d;
         mtvec_q       <= mtvec_d;
         wake_pc_q     <= wake_pc_d;
         mcycle_q      <= mcycle_d;
         minstret_q    <= minstret_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: expectations are queued when stimulus is
// applied and popped in order as the corresponding outputs are sampled.
module tb_csr_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        mret;
   logic        wfi;
   logic [31:0] pc_ex;
   logic        retire;
   logic        ext_irq;
   logic        tmr_irq;
   logic        interrupt;
   logic        redirect;
   logic [31:0] redirect_pc;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   csr_unit #(.MTVEC_RST(32'h0001_0000), .XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .csr_we(csr_we),
      .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
      .mret(mret), .wfi(wfi), .pc_ex(pc_ex), .retire(retire),
      .ext_irq(ext_irq), .tmr_irq(tmr_irq), .interrupt(interrupt),
      .redirect(redirect), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   task automatic exp(input string tag, input logic [31:0] v);
      exp_q.push_back(v);
      tag_q.push_back(tag);
   endtask

   task automatic check_out(input logic [31:0] obs);
      logic [31:0] e;
      string       t;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [11:0] a);
      csr_addr = a;
      #1;
      check_out(csr_rdata);
   endtask

   task automatic chk_redir();
      check_out({31'd0, redirect});
   endtask

   task automatic chk_int();
      #1;
      check_out({31'd0, interrupt});
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      csr_we    = 1'b1;
      csr_addr  = a;
      csr_wdata = d;
      step();
      csr_we    = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; csr_we = 1'b0; csr_addr = 12'h000;
      csr_wdata = 32'h0; mret = 1'b0; wfi = 1'b0; pc_ex = 32'h0;
      retire = 1'b0; ext_irq = 1'b0; tmr_irq = 1'b0;

      // Reset values
      exp("rst_redirect", 32'h0);
      exp("rst_mtvec", 32'h0001_0000);
      exp("rst_mstatus", 32'h0000_1800);
      repeat (2) @(posedge clk);
      #1;
      chk_redir();
      rd(12'h305);
      rd(12'h300);
      rst_n = 1'b1;
      step();

      // Enable MEIE and MIE
      exp("mie_wr", 32'h0000_0800);
      exp("mstatus_wr", 32'h0000_1808);
      wr(12'h304, 32'h0000_0800);
      rd(12'h304);
      wr(12'h300, 32'h0000_0008);
      rd(12'h300);

      // External interrupt at pc 0x120
      exp("irq_interrupt", 32'h1);
      exp("irq_mepc", 32'h0000_0120);
      exp("irq_mstatus", 32'h0000_1880);
      exp("irq_no_redirect_yet", 32'h0);
      exp("trap_redirect", 32'h1);
      exp("trap_redirect_pc", 32'h0001_0000);
      exp("trap_redirect_drop", 32'h0);
      pc_ex = 32'h0000_0120;
      ext_irq = 1'b1;
      chk_int();
      step();
      ext_irq = 1'b0;
      rd(12'h341);
      rd(12'h300);
      chk_redir();
      step();
      chk_redir();
      check_out(redirect_pc);
      step();
      chk_redir();

      // mret returns to mepc and restores MIE from MPIE
      exp("mret_redirect", 32'h1);
      exp("mret_redirect_pc", 32'h0000_0120);
      exp("mret_mstatus", 32'h0000_1888);
      exp("mret_redirect_drop", 32'h0);
      mret = 1'b1;
      step();
      mret = 1'b0;
      chk_redir();
      check_out(redirect_pc);
      rd(12'h300);
      step();
      chk_redir();

      // WFI with MIE=0, MTIE=1; timer wakes without trapping
      exp("wfi_mstatus", 32'h0000_1800);
      exp("sleep_no_redirect", 32'h0);
      exp("sleep_interrupt_masked", 32'h0);
      exp("wake_redirect", 32'h1);
      exp("wake_redirect_pc", 32'h0000_0204);
      exp("wake_mepc_kept", 32'h0000_0120);
      exp("sleep_write_ignored", 32'h0001_0000);
      wr(12'h300, 32'h0000_0000);
      rd(12'h300);
      wr(12'h304, 32'h0000_0080);
      pc_ex = 32'h0000_0200;
      wfi = 1'b1;
      step();
      wfi = 1'b0;
      wr(12'h305, 32'h0000_4000);
      repeat (3) step();
      chk_redir();
      tmr_irq = 1'b1;
      chk_int();
      step();
      chk_redir();
      check_out(redirect_pc);
      tmr_irq = 1'b0;
      rd(12'h341);
      rd(12'h305);
      step();

      // mcycle carry from low into high half, write wins over increment
      exp("mcycle_lo_loaded", 32'hFFFF_FFFF);
      exp("mcycle_lo_wrapped", 32'h0000_0000);
      exp("mcycle_hi_carry", 32'h0000_0001);
      exp("mcycle_lo_write_wins", 32'h0000_0055);
      exp("mcycle_hi_kept", 32'h0000_0001);
      wr(12'hB80, 32'h0000_0000);
      wr(12'hB00, 32'hFFFF_FFFF);
      rd(12'hB00);
      step();
      rd(12'hB00);
      rd(12'hB80);
      wr(12'hB00, 32'h0000_0055);
      rd(12'hB00);
      rd(12'hB80);

      // minstret counts retire only, write wins over increment
      exp("minstret_write", 32'h0000_0005);
      exp("minstret_inc", 32'h0000_0006);
      exp("minstret_hold", 32'h0000_0006);
      exp("minstreth", 32'h0000_0000);
      retire = 1'b1;
      wr(12'hB02, 32'h0000_0005);
      rd(12'hB02);
      step();
      retire = 1'b0;
      rd(12'hB02);
      step();
      rd(12'hB02);
      rd(12'hB82);

      // mtvec alignment, then csr_we to mtvec dropped by a concurrent interrupt
      exp("mtvec_aligned", 32'h0000_2000);
      exp("irq2_interrupt", 32'h1);
      exp("irq2_mtvec_kept", 32'h0000_2000);
      exp("irq2_mepc", 32'h0000_0300);
      exp("irq2_redirect", 32'h1);
      exp("irq2_redirect_pc", 32'h0000_2000);
      wr(12'h305, 32'h0000_2003);
      rd(12'h305);
      wr(12'h304, 32'h0000_0800);
      wr(12'h300, 32'h0000_0008);
      ext_irq = 1'b1;
      pc_ex = 32'h0000_0300;
      csr_we = 1'b1;
      csr_addr = 12'h305;
      csr_wdata = 32'h0000_4000;
      chk_int();
      step();
      csr_we = 1'b0;
      ext_irq = 1'b0;
      rd(12'h305);
      rd(12'h341);
      step();
      chk_redir();
      check_out(redirect_pc);
      step();

      // Stalled mret has no effect
      exp("stall_mret_redirect", 32'h0);
      exp("stall_mret_mstatus", 32'h0000_1880);
      exp("stall_mret_redirect2", 32'h0);
      stall = 1'b1;
      mret = 1'b1;
      step();
      chk_redir();
      rd(12'h300);
      step();
      chk_redir();
      stall = 1'b0;
      mret = 1'b0;

      // mip is read-only, unmapped addresses read 0, mepc alignment
      exp("mip_meip", 32'h0000_0800);
      exp("mip_both", 32'h0000_0880);
      exp("mip_write_ignored", 32'h0000_0880);
      exp("unmapped_zero", 32'h0000_0000);
      exp("mepc_aligned", 32'h0000_0124);
      ext_irq = 1'b1;
      rd(12'h344);
      tmr_irq = 1'b1;
      rd(12'h344);
      wr(12'h344, 32'h0000_0000);
      rd(12'h344);
      ext_irq = 1'b0;
      tmr_irq = 1'b0;
      wr(12'h123, 32'hFFFF_FFFF);
      rd(12'h123);
      wr(12'h341, 32'h0000_0127);
      rd(12'h341);

      // Reset while sleeping returns to RUN quietly
      exp("rst_sleep_redirect", 32'h0);
      exp("rst_sleep_mtvec", 32'h0001_0000);
      exp("post_rst_redirect", 32'h0);
      exp("post_rst_mstatus", 32'h0000_1800);
      pc_ex = 32'h0000_0400;
      wfi = 1'b1;
      step();
      wfi = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      chk_redir();
      rd(12'h305);
      rst_n = 1'b1;
      step();
      chk_redir();
      rd(12'h300);

      if (exp_q.size() != 0) begin
         errors++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
